// File: rtl/prover_layer_seq_if.sv
// Handshake bundle between the prover layer sequencer, its compute core and the verifier.
// The master side is the sequencer; the slave side is the core/verifier environment.
interface prover_layer_seq_if #(
    parameter int F_NBITS  = 16,
    parameter int NCOEF    = 4,
    parameter int CNT_BITS = 4
);
    logic                           comp_en;
    logic [CNT_BITS-1:0]            comp_round;
    logic [F_NBITS-1:0]             comp_tau;
    logic                           comp_ready;
    logic [NCOEF-1:0][F_NBITS-1:0]  coef_in;
    logic [NCOEF-1:0][F_NBITS-1:0]  c_out;
    logic                           c_valid;
    logic                           c_ack;
    logic [F_NBITS-1:0]             tau_in;
    logic                           tau_valid;

    modport master (
        output comp_en, comp_round, comp_tau, c_out, c_valid,
        input  comp_ready, coef_in, c_ack, tau_in, tau_valid
    );

    modport slave (
        input  comp_en, comp_round, comp_tau, c_out, c_valid,
        output comp_ready, coef_in, c_ack, tau_in, tau_valid
    );
endinterface

// File: rtl/prover_layer_seq.sv
// Prover-side sumcheck layer sequencer: per round kicks the core, offers masked
// coefficients to the verifier, then files the returned challenge into w3/w1/w2/tau_final.
module prover_layer_seq #(
    parameter int nInputs   = 8,
    parameter int nCopyBits = 3,
    parameter int F_NBITS   = 16,
    localparam int nInBits    = $clog2(nInputs),
    localparam int lastCoeff  = (nInBits < 3) ? 3 : nInBits,
    localparam int nCountBits = $clog2(nCopyBits + 2*nInBits + 1)
) (
    input  logic                              clk,
    input  logic                              rstb,
    input  logic                              en,
    prover_layer_seq_if.master                bus,
    output logic [nCopyBits-1:0][F_NBITS-1:0] w3_vals,
    output logic [nInBits-1:0][F_NBITS-1:0]   w1_vals,
    output logic [nInBits-1:0][F_NBITS-1:0]   w2_vals,
    output logic [F_NBITS-1:0]                tau_final,
    output logic                              ready,
    output logic                              fin_layer
);
    typedef enum logic [2:0] {IDLE, KICK, COMP, SEND, WAIT_TAU} state_t;

    localparam logic [nCountBits-1:0] LAST_ROUND = nCountBits'(nCopyBits + 2*nInBits);
    localparam logic [nCountBits-1:0] COPY_END   = nCountBits'(nCopyBits);

    state_t                              state_reg, state_next;
    logic                                en_dly_reg;
    logic [nCountBits-1:0]               count_reg;
    logic [F_NBITS-1:0]                  comp_tau_reg;
    logic [lastCoeff:0][F_NBITS-1:0]     c_out_reg;
    logic [lastCoeff:0][F_NBITS-1:0]     coef_masked;
    logic [nCopyBits-1:0][F_NBITS-1:0]   w3_reg;
    logic [nInBits-1:0][F_NBITS-1:0]     w1_reg;
    logic [nInBits-1:0][F_NBITS-1:0]     w2_reg;
    logic [F_NBITS-1:0]                  tau_final_reg;
    logic                                fin_reg;

    logic start, is_copy, is_final;
    logic do_start, latch_coef, store_tau;
    logic [nCopyBits-1:0] w3_hit;
    logic [nInBits-1:0]   w1_hit, w2_hit;

    assign start    = en & ~en_dly_reg;
    assign is_copy  = (count_reg < COPY_END);
    assign is_final = (count_reg == LAST_ROUND);

    // Copy rounds are cubic (c0..c3), w1/w2 rounds quadratic (c0..c2), final round keeps all.
    for (genvar gi = 0; gi <= lastCoeff; gi++) begin : g_mask
        if (gi < 3) begin : g_keep
            assign coef_masked[gi] = bus.coef_in[gi];
        end else if (gi == 3) begin : g_cubic
            assign coef_masked[gi] = (is_copy | is_final) ? bus.coef_in[gi] : '0;
        end else begin : g_line
            assign coef_masked[gi] = is_final ? bus.coef_in[gi] : '0;
        end
    end

    for (genvar gi = 0; gi < nCopyBits; gi++) begin : g_w3_hit
        assign w3_hit[gi] = store_tau && (count_reg == nCountBits'(gi));
    end

    for (genvar gi = 0; gi < nInBits; gi++) begin : g_w12_hit
        assign w1_hit[gi] = store_tau && (count_reg == nCountBits'(nCopyBits + gi));
        assign w2_hit[gi] = store_tau && (count_reg == nCountBits'(nCopyBits + nInBits + gi));
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        do_start   = 1'b0;
        latch_coef = 1'b0;
        store_tau  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    do_start   = 1'b1;
                    state_next = KICK;
                end
            end
            KICK: state_next = COMP;
            COMP: begin
                if (bus.comp_ready) begin
                    latch_coef = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (bus.c_ack) state_next = WAIT_TAU;
            end
            WAIT_TAU: begin
                if (bus.tau_valid) begin
                    store_tau  = 1'b1;
                    state_next = is_final ? IDLE : KICK;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            en_dly_reg    <= 1'b1;
            count_reg     <= '0;
            comp_tau_reg  <= '0;
            c_out_reg     <= '0;
            w3_reg        <= '0;
            w1_reg        <= '0;
            w2_reg        <= '0;
            tau_final_reg <= '0;
            fin_reg       <= 1'b0;
        end else begin
            en_dly_reg <= en;
            if (do_start) begin
                count_reg    <= '0;
                fin_reg      <= 1'b0;
                comp_tau_reg <= '0;
            end
            if (latch_coef) begin
                c_out_reg <= coef_masked;
            end
            if (store_tau) begin
                comp_tau_reg <= bus.tau_in;
                if (is_final) begin
                    tau_final_reg <= bus.tau_in;
                    fin_reg       <= 1'b1;
                end else begin
                    count_reg <= count_reg + nCountBits'(1);
                end
            end
            for (int i = 0; i < nCopyBits; i++) begin
                if (w3_hit[i]) w3_reg[i] <= bus.tau_in;
            end
            for (int i = 0; i < nInBits; i++) begin
                if (w1_hit[i]) w1_reg[i] <= bus.tau_in;
                if (w2_hit[i]) w2_reg[i] <= bus.tau_in;
            end
        end
    end

    assign bus.comp_en    = (state_reg == KICK);
    assign bus.comp_round = count_reg;
    assign bus.comp_tau   = comp_tau_reg;
    assign bus.c_out      = c_out_reg;
    assign bus.c_valid    = (state_reg == SEND);

    assign w3_vals   = w3_reg;
    assign w1_vals   = w1_reg;
    assign w2_vals   = w2_reg;
    assign tau_final = tau_final_reg;
    assign fin_layer = fin_reg;
    assign ready     = (state_reg == IDLE) && !start;
endmodule

// File: tb/tb_prover_layer_seq.sv
// Bench for prover_layer_seq with nCopyBits=1, nInputs=4: a handshake-level model of a
// layer run, a reactive core/verifier responder, and directed scenario checks.
module tb_prover_layer_seq;
    localparam int NIN   = 4;
    localparam int NCOPY = 1;
    localparam int FN    = 16;
    localparam int NINB  = 2;
    localparam int LASTC = 3;
    localparam int NC    = LASTC + 1;
    localparam int CB    = 3;
    localparam int LAST  = NCOPY + 2*NINB;

    logic clk = 1'b0;
    logic rstb, en;
    logic [NCOPY-1:0][FN-1:0] w3;
    logic [NINB-1:0][FN-1:0]  w1, w2;
    logic [FN-1:0]            tau_final;
    logic                     ready, fin_layer;

    prover_layer_seq_if #(.F_NBITS(FN), .NCOEF(NC), .CNT_BITS(CB)) bus ();

    prover_layer_seq #(.nInputs(NIN), .nCopyBits(NCOPY), .F_NBITS(FN)) dut (
        .clk       (clk),
        .rstb      (rstb),
        .en        (en),
        .bus       (bus),
        .w3_vals   (w3),
        .w1_vals   (w1),
        .w2_vals   (w2),
        .tau_final (tau_final),
        .ready     (ready),
        .fin_layer (fin_layer)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    endtask

    // Model of one layer run, stepped at each negedge with the inputs the bench drives.
    typedef enum int {M_IDLE, M_KICK, M_COMP, M_SEND, M_WAIT} mph_t;
    mph_t                 m_ph, m_prev;
    int                   m_age, m_round;
    logic [FN-1:0]        m_ctau;
    logic [NC-1:0][FN-1:0] m_cout;
    logic [FN-1:0]        m_slot [LAST+1];
    logic                 m_fin, m_en_prev, start_now;

    int  core_dly = 0, ack_dly = 0, tau_dly = 0, tau_base = 11;
    bit  spur = 1'b0;
    int  rounds_q[$];
    logic [NC-1:0][FN-1:0] cap0, cap1;

    task automatic model_reset();
        m_ph = M_IDLE; m_age = 0; m_round = 0; m_ctau = '0; m_cout = '0;
        for (int i = 0; i <= LAST; i++) m_slot[i] = '0;
        m_fin = 1'b0; m_en_prev = 1'b1;
    endtask

    function automatic logic [NC-1:0][FN-1:0] coef_for(input int r);
        logic [NC-1:0][FN-1:0] v;
        if (r <= 1) v = {16'd9, 16'd8, 16'd7, 16'd6};
        else for (int i = 0; i < NC; i++) v[i] = FN'(100*r + i + 1);
        return v;
    endfunction

    function automatic logic [NC-1:0][FN-1:0] exp_mask(input logic [NC-1:0][FN-1:0] c, input int r);
        logic [NC-1:0][FN-1:0] m;
        int hi;
        hi = (r < NCOPY) ? 3 : (r < LAST) ? 2 : LASTC;
        for (int i = 0; i < NC; i++) m[i] = (i <= hi) ? c[i] : '0;
        return m;
    endfunction

    always @(negedge clk) begin
        if (!rstb) model_reset();
        start_now = en && !m_en_prev;
        chk("comp_en",    64'(bus.comp_en),    64'(m_ph == M_KICK));
        chk("comp_round", 64'(bus.comp_round), 64'(m_round));
        chk("comp_tau",   64'(bus.comp_tau),   64'(m_ctau));
        chk("c_valid",    64'(bus.c_valid),    64'(m_ph == M_SEND));
        chk("c_out",      bus.c_out,           m_cout);
        for (int i = 0; i < NCOPY; i++) chk("w3_vals", 64'(w3[i]), 64'(m_slot[i]));
        for (int i = 0; i < NINB; i++) begin
            chk("w1_vals", 64'(w1[i]), 64'(m_slot[NCOPY+i]));
            chk("w2_vals", 64'(w2[i]), 64'(m_slot[NCOPY+NINB+i]));
        end
        chk("tau_final", 64'(tau_final), 64'(m_slot[LAST]));
        chk("fin_layer", 64'(fin_layer), 64'(m_fin));
        chk("ready",     64'(ready),     64'(m_ph == M_IDLE && !start_now));

        if (bus.comp_en) rounds_q.push_back(int'(bus.comp_round));
        if (bus.c_valid && m_age == 0 && m_round == 0) cap0 = bus.c_out;
        if (bus.c_valid && m_age == 0 && m_round == 1) cap1 = bus.c_out;

        bus.comp_ready = 1'b0; bus.coef_in = {NC{16'hdead}};
        bus.c_ack = 1'b0; bus.tau_valid = 1'b0; bus.tau_in = '0;
        case (m_ph)
            M_IDLE: begin bus.c_ack = 1'b1; bus.tau_valid = 1'b1; bus.tau_in = 16'd77; end
            M_KICK: bus.comp_ready = 1'b1;
            M_COMP: begin
                if (m_age >= core_dly) begin bus.comp_ready = 1'b1; bus.coef_in = coef_for(m_round); end
                if (spur) begin bus.tau_valid = 1'b1; bus.tau_in = 16'd99; bus.c_ack = 1'b1; end
            end
            M_SEND: begin
                bus.c_ack = (m_age >= ack_dly);
                if (spur) begin bus.tau_valid = 1'b1; bus.tau_in = 16'd99; end
            end
            M_WAIT: begin
                bus.c_ack = 1'b1;
                if (m_age >= tau_dly) begin bus.tau_valid = 1'b1; bus.tau_in = FN'(tau_base + m_round); end
            end
            default: ;
        endcase

        if (rstb) begin
            m_prev = m_ph;
            case (m_ph)
                M_IDLE: if (start_now) begin m_ph = M_KICK; m_round = 0; m_fin = 1'b0; m_ctau = '0; end
                M_KICK: m_ph = M_COMP;
                M_COMP: if (bus.comp_ready) begin m_cout = exp_mask(bus.coef_in, m_round); m_ph = M_SEND; end
                M_SEND: if (bus.c_ack) m_ph = M_WAIT;
                M_WAIT: if (bus.tau_valid) begin
                    m_slot[m_round] = bus.tau_in;
                    m_ctau = bus.tau_in;
                    if (m_round == LAST) begin m_fin = 1'b1; m_ph = M_IDLE; end
                    else begin m_round++; m_ph = M_KICK; end
                end
                default: ;
            endcase
            m_age = (m_ph == m_prev) ? m_age + 1 : 0;
            m_en_prev = en;
        end
    end

    task automatic start_pulse();
        @(posedge clk); #1 en = 1'b0;
        @(posedge clk); #1 en = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic wait_fin(input int budget);
        int k = 0;
        while (fin_layer !== 1'b1 && k < budget) begin @(posedge clk); #1; k++; end
        chk("fin_reached", 64'(fin_layer), 64'd1);
    endtask

    task automatic chk_rounds(input string nm);
        chk({nm, "_count"}, 64'(rounds_q.size()), 64'd6);
        for (int i = 0; i < rounds_q.size() && i < 6; i++) chk(nm, 64'(rounds_q[i]), 64'(i));
    endtask

    initial begin
        logic [NC-1:0][FN-1:0] e0, e1;
        int lat, k;
        e0 = {16'd9, 16'd8, 16'd7, 16'd6};
        e1 = {16'd0, 16'd8, 16'd7, 16'd6};
        rstb = 1'b1; en = 1'b0;
        bus.comp_ready = 1'b0; bus.coef_in = '0; bus.c_ack = 1'b0;
        bus.tau_in = '0; bus.tau_valid = 1'b0;
        #2 rstb = 1'b0;
        #1;
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_comp_en", 64'(bus.comp_en), 64'd0);
        chk("rst_c_valid", 64'(bus.c_valid), 64'd0);
        chk("rst_fin", 64'(fin_layer), 64'd0);
        chk("rst_c_out", bus.c_out, 64'd0);
        repeat (2) @(posedge clk);
        #1 rstb = 1'b1;

        // Run 1: core and verifier answer immediately; taus 11..16.
        rounds_q.delete();
        @(posedge clk); #1 en = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        while (fin_layer !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
        chk("latency", 64'(lat), 64'd24);
        chk("r1_w3_0", 64'(w3[0]), 64'd11);
        chk("r1_w1_0", 64'(w1[0]), 64'd12);
        chk("r1_w1_1", 64'(w1[1]), 64'd13);
        chk("r1_w2_0", 64'(w2[0]), 64'd14);
        chk("r1_w2_1", 64'(w2[1]), 64'd15);
        chk("r1_tau_final", 64'(tau_final), 64'd16);
        chk("r1_cout_round0", cap0, e0);
        chk("r1_cout_round1", cap1, e1);
        chk_rounds("r1_rounds");

        // Run 2: slow core, c_ack held off 5 cycles, stray tau=99 in COMP/SEND.
        core_dly = 2; ack_dly = 5; tau_dly = 1; spur = 1'b1; tau_base = 40;
        rounds_q.delete();
        start_pulse();
        wait_fin(400);
        chk("r2_comp_tau", 64'(bus.comp_tau), 64'd45);
        chk("r2_w3_0", 64'(w3[0]), 64'd40);
        chk("r2_tau_final", 64'(tau_final), 64'd45);
        chk_rounds("r2_rounds");
        spur = 1'b0;

        // Run 3: second start edge during round 2 is ignored.
        core_dly = 1; ack_dly = 1; tau_dly = 1; tau_base = 60;
        rounds_q.delete();
        start_pulse();
        k = 0;
        while (bus.comp_round != 3'd2 && k < 200) begin @(posedge clk); #1; k++; end
        chk("r3_reach_round2", 64'(bus.comp_round), 64'd2);
        en = 1'b0;
        @(posedge clk); #1 en = 1'b1;
        wait_fin(400);
        chk_rounds("r3_rounds");
        chk("r3_w1_1", 64'(w1[1]), 64'd62);

        // Run 4: reset while waiting for tau of round 3, then a clean restart.
        core_dly = 0; ack_dly = 0; tau_dly = 4; tau_base = 70;
        start_pulse();
        k = 0;
        while (!(bus.comp_round == 3'd3 && bus.c_valid) && k < 200) begin @(posedge clk); #1; k++; end
        while (bus.c_valid && k < 200) begin @(posedge clk); #1; k++; end
        chk("r4_in_wait_round3", 64'(bus.comp_round), 64'd3);
        rstb = 1'b0;
        #1;
        chk("r4_rst_round", 64'(bus.comp_round), 64'd0);
        chk("r4_rst_c_out", bus.c_out, 64'd0);
        chk("r4_rst_w3", 64'(w3[0]), 64'd0);
        chk("r4_rst_w1", 64'(w1[0]), 64'd0);
        chk("r4_rst_comp_tau", 64'(bus.comp_tau), 64'd0);
        chk("r4_rst_ready", 64'(ready), 64'd1);
        chk("r4_rst_fin", 64'(fin_layer), 64'd0);
        @(posedge clk); #1 rstb = 1'b1;
        tau_dly = 0; tau_base = 80;
        rounds_q.delete();
        start_pulse();
        wait_fin(300);
        chk_rounds("r4_rounds");
        chk("r4_w2_0", 64'(w2[0]), 64'd83);
        chk("r4_tau_final", 64'(tau_final), 64'd85);

        repeat (3) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
